// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART on the core I/O bus.
//
// Register map (word index relative to BASE_ADDR):
//   0 TXDATA  W: push byte into TX FIFO          R: 0
//   1 RXDATA  R: {24'b0, rx_byte}, clears rx_valid W: ignored
//   2 STATUS  R: {tx_ovf, rx_ferr, rx_ovr, rx_valid, tx_busy, tx_empty, tx_full}
//             W: write-1-to-clear of bits [6:4]
//   3 BAUDDIV R/W [15:0]; bit period = divisor + 1 clocks; writes below 3 store 3
//
// Ports:
//   clk, resetb           clock, asynchronous active-low reset
//   io_addr/io_en/io_we   register index, access strobe, write select
//   io_data_write         write data
//   io_data_read          combinational read data (0 unless a valid read)
//   uart_rx               serial input, asynchronous to clk
//   uart_tx               serial output, idle high
module io_uart #(
  parameter logic [7:0]  BASE_ADDR     = 8'h00,
  parameter int unsigned TX_DEPTH_LOG2 = 2,
  parameter logic [15:0] DIV_RESET     = 16'd104
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned Depth = 2 ** TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] DepthCnt = (TX_DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [7:0] off;
  logic       hit, wr, rd;
  logic       wr_txdata, rd_rxdata, wr_status, wr_baud;

  assign off       = io_addr - BASE_ADDR;
  assign hit       = io_en && (off[7:2] == 6'd0);
  assign wr        = hit && io_we;
  assign rd        = hit && !io_we;
  assign wr_txdata = wr && (off[1:0] == 2'd0);
  assign rd_rxdata = rd && (off[1:0] == 2'd1);
  assign wr_status = wr && (off[1:0] == 2'd2);
  assign wr_baud   = wr && (off[1:0] == 2'd3);

  logic unused_wdata;
  assign unused_wdata = ^io_data_write[31:16];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0] div_q, div_d;

  logic [7:0]               fifo_q [Depth];
  logic [7:0]               fifo_d [Depth];
  logic [TX_DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [TX_DEPTH_LOG2:0]   cnt_q, cnt_d;

  tx_state_e   tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  logic        sync1_q, sync2_q;
  rx_state_e   rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        rx_ferr_q, rx_ferr_d;
  logic        tx_ovf_q, tx_ovf_d;

  logic tx_full, tx_empty, tx_busy, push, pop;
  logic rx_done, rx_s;
  logic set_ovr, set_ferr;
  logic [15:0] rx_half_m1;

  assign tx_full  = (cnt_q == DepthCnt);
  assign tx_empty = (cnt_q == '0);
  assign tx_busy  = (tx_st_q != TxIdle) || !tx_empty;
  // Full is judged before the edge: a same-cycle pop does not make room.
  assign push     = wr_txdata && !tx_full;
  assign pop      = (tx_st_q == TxIdle) && !tx_empty;
  assign rx_s     = sync2_q;
  // (div+1)/2 - 1 without a 17-bit intermediate; div is never below 3.
  assign rx_half_m1 = (div_q - 16'd1) >> 1;
  assign uart_tx  = tx_q;

  // ---------------------------------------------------------------------------
  // Divisor and TX FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d = div_q;
    if (wr_baud) begin
      div_d = (io_data_write[15:0] < 16'd3) ? 16'd3 : io_data_write[15:0];
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wptr_q] = io_data_write[7:0];
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // TX serializer: each bit lasts div+1 cycles, divisor reloaded per bit
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_st_q_hold: begin end
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    unique case (tx_st_q)
      TxIdle: begin
        if (pop) begin
          tx_st_d  = TxStart;
          tx_sh_d  = fifo_q[rptr_q];
          tx_cnt_d = div_q;
          tx_d     = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == '0) begin
          tx_st_d  = TxData;
          tx_cnt_d = div_q;
          tx_idx_d = '0;
          tx_d     = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TxData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_q;
          if (tx_idx_q == 3'd7) begin
            tx_st_d = TxStop;
            tx_d    = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == '0) begin
          tx_st_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_st_d = TxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX deserializer: START waits half a bit, then samples every div+1 cycles
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_idx_d = rx_idx_q;
    rx_sh_d  = rx_sh_q;
    rx_done  = 1'b0;
    unique case (rx_st_q)
      RxIdle: begin
        if (!rx_s) begin
          rx_st_d  = RxStart;
          rx_cnt_d = rx_half_m1;
        end
      end
      RxStart: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) begin
            rx_st_d = RxIdle;  // line went back high: glitch
          end else begin
            rx_st_d  = RxData;
            rx_cnt_d = div_q;
            rx_idx_d = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          rx_cnt_d = div_q;
          if (rx_idx_q == 3'd7) begin
            rx_st_d = RxStop;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == '0) begin
          rx_st_d = RxIdle;
          rx_done = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_st_d = RxIdle;
    endcase
  end

  // Holding register and sticky flags; a flag being set beats a same-edge clear.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    set_ovr    = 1'b0;
    set_ferr   = 1'b0;
    if (rd_rxdata) begin
      rx_valid_d = 1'b0;
    end
    if (rx_done) begin
      if (!rx_s) begin
        set_ferr = 1'b1;
      end else if (rx_valid_q && !rd_rxdata) begin
        set_ovr = 1'b1;
      end else begin
        rx_byte_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end
    end
    rx_ovr_d  = (rx_ovr_q  && !(wr_status && io_data_write[4])) || set_ovr;
    rx_ferr_d = (rx_ferr_q && !(wr_status && io_data_write[5])) || set_ferr;
    tx_ovf_d  = (tx_ovf_q  && !(wr_status && io_data_write[6])) || (wr_txdata && tx_full);
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    io_data_read = '0;
    if (rd) begin
      unique case (off[1:0])
        2'd0: io_data_read = '0;
        2'd1: io_data_read = {24'd0, rx_byte_q};
        2'd2: io_data_read = {25'd0, tx_ovf_q, rx_ferr_q, rx_ovr_q, rx_valid_q,
                              tx_busy, tx_empty, tx_full};
        default: io_data_read = {16'd0, div_q};
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_q      <= DIV_RESET;
      for (int i = 0; i < Depth; i++) fifo_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tx_st_q    <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_st_q    <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: bus register behaviour, TX waveform against
// an ideal 8N1 bit stream, RX against a frame-level holding-register model.
module tb_io_uart;

  localparam logic [7:0] ATx = 8'd0, ARx = 8'd1, ASt = 8'd2, ABd = 8'd3;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [7:0]  io_addr = '0;
  logic        io_en = 1'b0;
  logic        io_we = 1'b0;
  logic [31:0] io_data_write = '0;
  logic [31:0] io_data_read;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int n_tests = 0;
  int n_fail  = 0;

  io_uart #(
    .BASE_ADDR    (8'h00),
    .TX_DEPTH_LOG2(2),
    .DIV_RESET    (16'd104)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .io_addr      (io_addr),
    .io_en        (io_en),
    .io_we        (io_we),
    .io_data_write(io_data_write),
    .io_data_read (io_data_read),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx)
  );

  always #5 clk = ~clk;

  // uart_tx recorded once per cycle, 2 time units after each rising edge.
  bit   rec_en = 1'b0;
  logic trace[$];
  logic exp_q[$];
  always @(posedge clk) begin
    #2;
    if (rec_en) trace.push_back(uart_tx);
  end

  // RX reference model: what firmware should see after each whole frame.
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_byte = '0;

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_byte  = b;
      m_valid = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_status_idle();
    return {25'd0, 1'b0, m_ferr, m_ovr, m_valid, 3'b010};
  endfunction

  // Bus tasks; called just after a falling edge, the access lands on the next rising edge.
  task automatic io_write(input logic [7:0] a, input logic [31:0] d);
    io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
    @(negedge clk);
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [31:0] d);
    io_en = 1'b1; io_we = 1'b0; io_addr = a;
    #1 d = io_data_read;
    @(negedge clk);
    io_en = 1'b0;
  endtask

  // Ideal 8N1 stream: start 0, data LSB first, stop 1; each bit div+1 cycles.
  task automatic exp_add_frame(input logic [7:0] b, input int div, input bit gap);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) repeat (div + 1) exp_q.push_back(bits[j]);
    if (gap) exp_q.push_back(1'b1);
  endtask

  // Waits (bounded) for the trace to cover exp_q; idx = first mismatch, -1 none, -2 timeout.
  task automatic trace_diff(output int idx, output logic act, output logic expv);
    int budget;
    budget = 4000;
    idx = -1; act = 1'b0; expv = 1'b0;
    while (trace.size() < exp_q.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (trace.size() < exp_q.size()) idx = -2;
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (idx == -1 && trace[i] !== exp_q[i]) begin
          idx = i; act = trace[i]; expv = exp_q[i];
        end
      end
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      uart_rx = bits[j];
      repeat (div + 1) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (div + 1) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    int bad;
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (uart_tx !== 1'b1 || io_data_read !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: uart_tx=%b read=%h, want 1 and 0", uart_tx, io_data_read);
    end
    resetb = 1'b1;
    @(negedge clk);
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want 2", d); end
    io_read(ABd, d);
    n_tests++;
    if (d !== 32'd104) begin n_fail++; $display("FAIL reset_baud: got %0d want 104", d); end
    io_read(ATx, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", d); end
    io_read(8'd4, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL out_of_range: got %h want 0", d); end
    // Write cycle and disabled strobe both read as zero.
    io_en = 1'b1; io_we = 1'b1; io_addr = ABd; io_data_write = 32'd104;
    #1;
    n_tests++;
    if (io_data_read !== 32'd0) begin
      n_fail++; $display("FAIL read_on_write: got %h want 0", io_data_read);
    end
    @(negedge clk);
    io_en = 1'b0; io_we = 1'b0;
    #1;
    n_tests++;
    if (io_data_read !== 32'd0) begin
      n_fail++; $display("FAIL read_no_en: got %h want 0", io_data_read);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL tx_idle_high: %0d low cycles, want 0", bad); end
  endtask

  task automatic test_baud_clamp();
    logic [31:0] wv [5];
    logic [31:0] ev [5];
    logic [31:0] d;
    wv = '{32'd0, 32'd1, 32'd2, 32'd3, 32'hABCD_0004};
    ev = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd4};
    for (int i = 0; i < 5; i++) begin
      io_write(ABd, wv[i]);
      io_read(ABd, d);
      n_tests++;
      if (d !== ev[i]) begin
        n_fail++; $display("FAIL baud_clamp[%0d]: wrote %h read %h want %h", i, wv[i], d, ev[i]);
      end
    end
  endtask

  task automatic test_tx_frame();
    logic [31:0] d;
    int idx;
    logic act, expv;
    logic [7:0] b;
    int div;
    io_write(ABd, 32'd9);
    trace.delete(); exp_q.delete();
    exp_q.push_back(1'b1);  // write edge: byte only just queued
    exp_add_frame(8'h55, 9, 1'b0);
    rec_en = 1'b1;
    io_write(ATx, 32'h55);
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL tx_queued_status: got %h want 4", d); end
    trace_diff(idx, act, expv);
    n_tests++;
    if (idx != -1) begin
      n_fail++; $display("FAIL tx_frame_55: idx %0d got %b want %b", idx, act, expv);
    end
    // Last stop-bit cycle still busy; the next cycle is idle.
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL tx_stop_busy: got %h want 6", d); end
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL tx_done_status: got %h want 2", d); end
    rec_en = 1'b0;
    // Random byte at a random (possibly minimum) divisor.
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      div = (k == 0) ? 3 : int'($urandom_range(4, 12));
      io_write(ABd, 32'(div));
      trace.delete(); exp_q.delete();
      exp_q.push_back(1'b1);
      exp_add_frame(b, div, 1'b1);
      rec_en = 1'b1;
      io_write(ATx, {24'd0, b});
      trace_diff(idx, act, expv);
      rec_en = 1'b0;
      n_tests++;
      if (idx != -1) begin
        n_fail++;
        $display("FAIL tx_frame_rand: byte %h div %0d idx %0d got %b want %b", b, div, idx, act,
                 expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [6];
    logic [31:0] d;
    int idx;
    logic act, expv;
    io_write(ABd, 32'd9);
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    trace.delete(); exp_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 0; i < 5; i++) exp_add_frame(b[i], 9, 1'b1);
    rec_en = 1'b1;
    for (int i = 0; i < 6; i++) io_write(ATx, {24'd0, b[i]});
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h45) begin n_fail++; $display("FAIL b2b_overflow: got %h want 45", d); end
    io_write(ASt, 32'h40);
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h05) begin n_fail++; $display("FAIL b2b_w1c: got %h want 05", d); end
    trace_diff(idx, act, expv);
    rec_en = 1'b0;
    n_tests++;
    if (idx != -1) begin
      n_fail++; $display("FAIL b2b_wire: idx %0d got %b want %b", idx, act, expv);
    end
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h02) begin n_fail++; $display("FAIL b2b_final_status: got %h want 2", d); end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic [7:0] b;
    int div;
    for (int k = 0; k < 4; k++) begin
      b   = (k == 0) ? 8'hA3 : 8'($urandom);
      div = (k == 0) ? 9 : int'($urandom_range(7, 15));
      io_write(ABd, 32'(div));
      rx_send(b, 1'b1, div);
      model_frame(b, 1'b1);
      io_read(ASt, d);
      n_tests++;
      if (d !== exp_status_idle()) begin
        n_fail++; $display("FAIL rx_valid[%0d]: got %h want %h", k, d, exp_status_idle());
      end
      io_read(ARx, d);
      n_tests++;
      if (d !== {24'd0, m_byte}) begin
        n_fail++; $display("FAIL rx_data[%0d]: got %h want %h", k, d, m_byte);
      end
      m_valid = 1'b0;
      io_read(ASt, d);
      n_tests++;
      if (d !== exp_status_idle()) begin
        n_fail++; $display("FAIL rx_cleared[%0d]: got %h want %h", k, d, exp_status_idle());
      end
    end
  endtask

  task automatic test_rx_errors();
    logic [31:0] d;
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    io_write(ABd, 32'd9);
    rx_send(b[0], 1'b1, 9); model_frame(b[0], 1'b1);
    rx_send(b[1], 1'b1, 9); model_frame(b[1], 1'b1);
    io_read(ASt, d);
    n_tests++;
    if (d !== exp_status_idle() || d !== 32'h1A) begin
      n_fail++; $display("FAIL rx_overrun: got %h want %h", d, exp_status_idle());
    end
    io_read(ARx, d);
    m_valid = 1'b0;
    n_tests++;
    if (d !== {24'd0, m_byte}) begin
      n_fail++; $display("FAIL rx_ovr_keeps_first: got %h want %h", d, m_byte);
    end
    io_write(ASt, 32'h10);
    m_ovr = 1'b0;
    rx_send(b[2], 1'b1, 9); model_frame(b[2], 1'b1);
    rx_send(b[3], 1'b0, 9); model_frame(b[3], 1'b0);
    io_read(ASt, d);
    n_tests++;
    if (d !== exp_status_idle()) begin
      n_fail++; $display("FAIL rx_ferr: got %h want %h", d, exp_status_idle());
    end
    io_read(ARx, d);
    m_valid = 1'b0;
    n_tests++;
    if (d !== {24'd0, m_byte}) begin
      n_fail++; $display("FAIL rx_ferr_discard: got %h want %h", d, m_byte);
    end
    io_write(ASt, 32'h20);
    m_ferr = 1'b0;
    // Short low pulse must be rejected as a glitch.
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    io_read(ASt, d);
    n_tests++;
    if (d !== exp_status_idle()) begin
      n_fail++; $display("FAIL rx_glitch: got %h want %h", d, exp_status_idle());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int bad;
    io_write(ABd, 32'd9);
    io_write(ATx, 32'h00);
    repeat (30) @(negedge clk);
    n_tests++;
    if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_frame_low: got %b want 0", uart_tx); end
    #2 resetb = 1'b0;
    #1;
    n_tests++;
    if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL async_tx_high: got %b want 1", uart_tx); end
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = '0;
    io_read(ASt, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL post_reset_status: got %h want 2", d); end
    io_read(ABd, d);
    n_tests++;
    if (d !== 32'd104) begin n_fail++; $display("FAIL post_reset_baud: got %0d want 104", d); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL post_reset_idle: %0d low cycles want 0", bad); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_baud_clamp();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_rx_errors();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
